int_exc_ctrl: RTL and testbench

INT_EXC_CTRL -- requirements
Module: int_exc_ctrl

---
 rtl/cpu_exc_defs.sv | 37 +++
 rtl/irq_pend_latch.sv | 48 ++++
 rtl/int_exc_ctrl.sv | 131 +++++++++++++
 tb/tb_int_exc_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_exc_defs.sv
// Shared exception definitions: cause codes, Status bit positions and the
// exception-sequencer state encoding used by CP0, decode and the controller.
package cpu_exc_defs;

    localparam int unsigned MaxIrq = 8;
    localparam int unsigned IdxW   = 3;

    // CP0 Status bit positions
    localparam int unsigned StatusGie   = 0;
    localparam int unsigned StatusSysEn = 1;
    localparam int unsigned StatusBrkEn = 2;
    localparam int unsigned StatusTeqEn = 3;
    localparam int unsigned StatusIrqEn = 4;

    localparam logic [4:0] CauseInt = 5'b00000;
    localparam logic [4:0] CauseSys = 5'b01000;
    localparam logic [4:0] CauseBrk = 5'b01001;
    localparam logic [4:0] CauseTeq = 5'b01101;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEnter   = 2'd1,
        StHandler = 2'd2,
        StReturn  = 2'd3
    } exc_state_e;

    // Synchronous-event cause with syscall > break > teq priority.
    function automatic logic [4:0] sync_cause(input logic sys_ev, input logic brk_ev);
        if (sys_ev) begin
            return CauseSys;
        end else if (brk_ev) begin
            return CauseBrk;
        end
        return CauseTeq;
    endfunction

endpackage

// File: rtl/irq_pend_latch.sv
// Interrupt request edge detector, sticky pending register and
// lowest-index priority encoder.
module irq_pend_latch
    import cpu_exc_defs::*;
#(
    parameter int unsigned NIRQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] intr_req,
    input  logic [NIRQ-1:0] ack,
    output logic [NIRQ-1:0] pending,
    output logic            any_pending,
    output logic [IdxW-1:0] win_idx
);

    logic [NIRQ-1:0] req_prev;
    logic [NIRQ-1:0] req_rise;
    logic [NIRQ-1:0] pending_d;

    // A fresh rising edge wins over an acknowledge clear of the same line.
    always_comb begin
        req_rise  = intr_req & ~req_prev;
        pending_d = (pending & ~ack) | req_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev <= '0;
            pending  <= '0;
        end else begin
            req_prev <= intr_req;
            pending  <= pending_d;
        end
    end

    always_comb begin
        win_idx = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = IdxW'(i);
            end
        end
    end

    assign any_pending = |pending;

endmodule

// File: rtl/int_exc_ctrl.sv
// Interrupt / exception sequencer: IDLE -> ENTER -> HANDLER -> RETURN with
// registered CP0 strobes and stall, plus a sticky protocol-error flag.
module int_exc_ctrl
    import cpu_exc_defs::*;
#(
    parameter int unsigned NIRQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] intr_req,
    input  logic            syscall,
    input  logic            brk,
    input  logic            teq_hit,
    input  logic            eret,
    input  logic [31:0]     status,
    output logic            cp0_exception,
    output logic [4:0]      cp0_cause,
    output logic            cp0_intr,
    output logic            cp0_eret,
    output logic            stall,
    output logic            in_handler,
    output logic [NIRQ-1:0] intr_ack,
    output logic [NIRQ-1:0] pending,
    output logic            err
);

    exc_state_e      state;
    logic            any_pending;
    logic [IdxW-1:0] win_idx;
    logic [NIRQ-1:0] win_ack;
    logic            sys_ev;
    logic            brk_ev;
    logic            teq_ev;
    logic            sync_ev;
    logic            irq_ev;
    logic            unused_status;

    assign unused_status = ^status[31:5];

    irq_pend_latch #(
        .NIRQ(NIRQ)
    ) u_pend (
        .clk        (clk),
        .rst        (rst),
        .intr_req   (intr_req),
        .ack        (intr_ack),
        .pending    (pending),
        .any_pending(any_pending),
        .win_idx    (win_idx)
    );

    always_comb begin
        sys_ev  = status[StatusGie] & status[StatusSysEn] & syscall;
        brk_ev  = status[StatusGie] & status[StatusBrkEn] & brk;
        teq_ev  = status[StatusGie] & status[StatusTeqEn] & teq_hit;
        sync_ev = sys_ev | brk_ev | teq_ev;
        irq_ev  = status[StatusGie] & status[StatusIrqEn] & any_pending;
    end

    always_comb begin
        win_ack = '0;
        for (int i = 0; i < int'(NIRQ); i++) begin
            win_ack[i] = (win_idx == IdxW'(i));
        end
    end

    // Strobes default low every cycle; only the transition into ENTER or
    // RETURN raises them, so each lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            cp0_exception <= 1'b0;
            cp0_cause     <= '0;
            cp0_intr      <= 1'b0;
            cp0_eret      <= 1'b0;
            stall         <= 1'b0;
            in_handler    <= 1'b0;
            intr_ack      <= '0;
            err           <= 1'b0;
        end else begin
            cp0_exception <= 1'b0;
            cp0_cause     <= '0;
            cp0_intr      <= 1'b0;
            cp0_eret      <= 1'b0;
            stall         <= 1'b0;
            intr_ack      <= '0;
            unique case (state)
                StIdle: begin
                    if (eret) begin
                        err <= 1'b1;
                    end
                    if (sync_ev) begin
                        state         <= StEnter;
                        cp0_exception <= 1'b1;
                        cp0_cause     <= sync_cause(sys_ev, brk_ev);
                        stall         <= 1'b1;
                    end else if (irq_ev) begin
                        state         <= StEnter;
                        cp0_exception <= 1'b1;
                        cp0_cause     <= CauseInt;
                        cp0_intr      <= 1'b1;
                        intr_ack      <= win_ack;
                        stall         <= 1'b1;
                    end
                end
                StEnter: begin
                    state      <= StHandler;
                    in_handler <= 1'b1;
                end
                StHandler: begin
                    if (sync_ev) begin
                        err <= 1'b1;
                    end
                    if (eret) begin
                        state      <= StReturn;
                        in_handler <= 1'b0;
                        cp0_eret   <= 1'b1;
                        stall      <= 1'b1;
                    end
                end
                StReturn: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_exc_ctrl.sv
// Self-checking bench for int_exc_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_int_exc_ctrl;

    localparam int NIRQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NIRQ-1:0] intr_req = '0;
    logic            syscall = 1'b0;
    logic            brk = 1'b0;
    logic            teq_hit = 1'b0;
    logic            eret = 1'b0;
    logic [31:0]     status = 32'h0;
    logic            cp0_exception;
    logic [4:0]      cp0_cause;
    logic            cp0_intr;
    logic            cp0_eret;
    logic            stall;
    logic            in_handler;
    logic [NIRQ-1:0] intr_ack;
    logic [NIRQ-1:0] pending;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 idle, 1 enter, 2 handler, 3 return.
    int        m_phase;
    bit [3:0]  m_pend, m_prev, m_ack;
    bit [4:0]  m_cause;
    bit        m_exc, m_intr, m_eret, m_stall, m_inh, m_err;

    int_exc_ctrl #(
        .NIRQ(NIRQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .intr_req     (intr_req),
        .syscall      (syscall),
        .brk          (brk),
        .teq_hit      (teq_hit),
        .eret         (eret),
        .status       (status),
        .cp0_exception(cp0_exception),
        .cp0_cause    (cp0_cause),
        .cp0_intr     (cp0_intr),
        .cp0_eret     (cp0_eret),
        .stall        (stall),
        .in_handler   (in_handler),
        .intr_ack     (intr_ack),
        .pending      (pending),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pend = 0; m_prev = 0; m_ack = 0; m_cause = 0;
        m_exc = 0; m_intr = 0; m_eret = 0; m_stall = 0; m_inh = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit [3:0] new_pend;
        bit       g, s, b, t;
        g = status[0];
        s = g & status[1] & syscall;
        b = g & status[2] & brk;
        t = g & status[3] & teq_hit;
        new_pend = (m_pend & ~m_ack) | (intr_req & ~m_prev);
        m_prev = intr_req;
        m_exc = 0; m_cause = 0; m_intr = 0; m_ack = 0; m_eret = 0; m_stall = 0;
        case (m_phase)
            0: begin
                if (eret) m_err = 1;
                if (s || b || t) begin
                    m_phase = 1; m_exc = 1; m_stall = 1;
                    m_cause = s ? 5'd8 : (b ? 5'd9 : 5'd13);
                end else if (g && status[4] && m_pend != 0) begin
                    m_phase = 1; m_exc = 1; m_stall = 1; m_intr = 1;
                    for (int k = 3; k >= 0; k--) if (m_pend[k]) m_ack = 4'(1 << k);
                end
            end
            1: begin m_phase = 2; m_inh = 1; end
            2: begin
                if (s || b || t) m_err = 1;
                if (eret) begin m_phase = 3; m_inh = 0; m_eret = 1; m_stall = 1; end
            end
            default: m_phase = 0;
        endcase
        m_pend = new_pend;
    endtask

    task automatic compare_all();
        check("cp0_exception", 32'(cp0_exception), 32'(m_exc));
        check("cp0_cause", 32'(cp0_cause), 32'(m_cause));
        check("cp0_intr", 32'(cp0_intr), 32'(m_intr));
        check("cp0_eret", 32'(cp0_eret), 32'(m_eret));
        check("stall", 32'(stall), 32'(m_stall));
        check("in_handler", 32'(in_handler), 32'(m_inh));
        check("intr_ack", 32'(intr_ack), 32'(m_ack));
        check("pending", 32'(pending), 32'(m_pend));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic clear_ins();
        syscall = 0; brk = 0; teq_hit = 0; eret = 0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Syscall entry with one-cycle latency, then handler
        status = 32'h1F; syscall = 1;
        cycle();
        check("sys_exc", 32'(cp0_exception), 32'd1);
        check("sys_cause", 32'(cp0_cause), 32'h08);
        check("sys_stall", 32'(stall), 32'd1);
        clear_ins();
        cycle();
        check("sys_inh", 32'(in_handler), 32'd1);
        eret = 1; cycle(); eret = 0; cycle();

        // Break beats a same-cycle interrupt edge; interrupt follows the return
        brk = 1; intr_req = 4'b0100;
        cycle();
        check("brk_cause", 32'(cp0_cause), 32'h09);
        check("brk_pend", 32'(pending), 32'h4);
        brk = 0;
        cycle();
        check("brk_pend_hold", 32'(pending), 32'h4);
        eret = 1; cycle(); eret = 0; cycle(); cycle();
        check("irq2_ack", 32'(intr_ack), 32'h4);
        check("irq2_intr", 32'(cp0_intr), 32'd1);
        check("irq2_cause", 32'(cp0_cause), 32'h00);
        cycle();
        check("irq2_clr", 32'(pending), 32'h0);
        eret = 1; cycle(); eret = 0; cycle();
        intr_req = 0; cycle();

        // Simultaneous lines 1 and 3: lowest index first
        intr_req = 4'b1010;
        cycle(); cycle();
        check("irq13_first", 32'(intr_ack), 32'h2);
        cycle();
        eret = 1; cycle(); eret = 0; cycle(); cycle();
        check("irq13_second", 32'(intr_ack), 32'h8);
        cycle(); eret = 1; cycle(); eret = 0; cycle();
        intr_req = 0; cycle();

        // Disabled syscall ignored; teq in handler dropped with err
        status = 32'h1D; syscall = 1;
        cycle();
        check("sysdis_exc", 32'(cp0_exception), 32'd0);
        syscall = 0; cycle();
        check("sysdis_idle", 32'(in_handler), 32'd0);
        status = 32'h1F; brk = 1; cycle(); brk = 0; cycle();
        teq_hit = 1; cycle(); teq_hit = 0;
        check("teq_drop_exc", 32'(cp0_exception), 32'd0);
        check("teq_err", 32'(err), 32'd1);
        eret = 1; cycle(); eret = 0; cycle();

        // Stray eret in idle, then reset from inside the handler
        do_reset();
        status = 32'h1F; eret = 1;
        cycle();
        check("eret_idle_strobe", 32'(cp0_eret), 32'd0);
        check("eret_idle_err", 32'(err), 32'd1);
        eret = 0; syscall = 1; cycle(); syscall = 0;
        intr_req = 4'b0001; cycle(); cycle();
        check("rst_pre_inh", 32'(in_handler), 32'd1);
        do_reset();
        check("rst_inh", 32'(in_handler), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            status   = ($urandom_range(0, 3) == 0) ? {27'($urandom), 5'($urandom)}
                                                   : {27'($urandom), 5'h1F};
            syscall  = ($urandom_range(0, 15) == 0);
            brk      = ($urandom_range(0, 15) == 0);
            teq_hit  = ($urandom_range(0, 15) == 0);
            eret     = ($urandom_range(0, (m_phase == 2) ? 2 : 20) == 0);
            if ($urandom_range(0, 3) == 0) intr_req = 4'($urandom);
            if ($urandom_range(0, 300) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
